// File: rtl/eco32f_rf_wport_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, the MDU
// result is parked in a one-entry buffer and the debug write waits for a free slot.
// A starvation counter raises pipe_hold when a parked write is denied for too long.
module eco32f_rf_wport_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_rf_r_we,
   input  logic [4:0]  pipe_rf_r_addr,
   input  logic [31:0] pipe_rf_r,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_addr,
   input  logic [31:0] mdu_result,
   input  logic        dbg_req,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ack,
   output logic        pipe_hold,
   output logic        buf_valid,
   output logic [4:0]  buf_addr,
   output logic [31:0] buf_data,
   output logic        wb_rf_r_we,
   output logic [4:0]  wb_rf_r_addr,
   output logic [31:0] wb_rf_r
);

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam logic [CNT_WIDTH-1:0] LP_LIMIT = CNT_WIDTH'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_WAIT = 2'd1,
      D_ACK  = 2'd2
   } dbg_state_t;

   typedef enum logic {
      RR_MDU = 1'b0,
      RR_DBG = 1'b1
   } rr_t;

   dbg_state_t           r_dbg_state;
   rr_t                  r_rr;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_hold;
   logic                 r_dbg_ack;
   logic                 r_buf_valid;
   logic [AW-1:0]        r_buf_addr;
   logic [DW-1:0]        r_buf_data;
   logic                 r_wb_we;
   logic [AW-1:0]        r_wb_addr;
   logic [DW-1:0]        r_wb_data;

   logic w_buf_pend;
   logic w_dbg_pend;
   logic w_contest;
   logic w_grant_buf;
   logic w_grant_dbg;
   logic w_any_pend;
   logic w_any_grant;
   logic w_waw_drop;
   logic w_mdu_load;

   assign w_buf_pend  = r_buf_valid;
   assign w_dbg_pend  = (r_dbg_state == D_WAIT);
   assign w_any_pend  = w_buf_pend | w_dbg_pend;
   assign w_contest   = !pipe_rf_r_we && w_buf_pend && w_dbg_pend;
   assign w_any_grant = w_grant_buf | w_grant_dbg;

   // A younger pipeline write to the parked register makes the parked value dead.
   assign w_waw_drop  = r_buf_valid && pipe_rf_r_we &&
                        (pipe_rf_r_addr == r_buf_addr) && (r_buf_addr != '0);

   assign mdu_ready   = !r_buf_valid || w_grant_buf;
   assign w_mdu_load  = mdu_valid && mdu_ready;

   assign dbg_ack      = r_dbg_ack;
   assign pipe_hold    = r_hold;
   assign buf_valid    = r_buf_valid;
   assign buf_addr     = r_buf_addr;
   assign buf_data     = r_buf_data;
   assign wb_rf_r_we   = r_wb_we;
   assign wb_rf_r_addr = r_wb_addr;
   assign wb_rf_r      = r_wb_data;

   // Grant one parked requester when the pipeline leaves the port free.
   always_comb begin
      w_grant_buf = 1'b0;
      w_grant_dbg = 1'b0;
      if (!pipe_rf_r_we) begin
         if (w_buf_pend && w_dbg_pend) begin
            if (r_rr == RR_MDU) begin
               w_grant_buf = 1'b1;
            end else begin
               w_grant_dbg = 1'b1;
            end
         end else if (w_buf_pend) begin
            w_grant_buf = 1'b1;
         end else if (w_dbg_pend) begin
            w_grant_dbg = 1'b1;
         end
      end
   end

   // Registered write port; writes to $0 are suppressed but still consume the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_we   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else if (pipe_rf_r_we) begin
         r_wb_we   <= (pipe_rf_r_addr != '0);
         r_wb_addr <= pipe_rf_r_addr;
         r_wb_data <= pipe_rf_r;
      end else if (w_grant_buf) begin
         r_wb_we   <= (r_buf_addr != '0);
         r_wb_addr <= r_buf_addr;
         r_wb_data <= r_buf_data;
      end else if (w_grant_dbg) begin
         r_wb_we   <= (dbg_addr != '0);
         r_wb_addr <= dbg_addr;
         r_wb_data <= dbg_wdata;
      end else begin
         r_wb_we   <= 1'b0;
      end
   end

   // MDU holding buffer: a new load beats both a grant and a WAW drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_valid <= 1'b0;
         r_buf_addr  <= '0;
         r_buf_data  <= '0;
      end else if (w_mdu_load) begin
         r_buf_valid <= 1'b1;
         r_buf_addr  <= mdu_addr;
         r_buf_data  <= mdu_result;
      end else if (w_grant_buf || w_waw_drop) begin
         r_buf_valid <= 1'b0;
      end
   end

   // Debug handshake FSM; dbg_ack lines up with the write it acknowledges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dbg_state <= D_IDLE;
         r_dbg_ack   <= 1'b0;
      end else begin
         r_dbg_ack <= 1'b0;
         case (r_dbg_state)
            D_IDLE: begin
               if (dbg_req) begin
                  r_dbg_state <= D_WAIT;
               end
            end
            D_WAIT: begin
               if (w_grant_dbg) begin
                  r_dbg_state <= D_ACK;
                  r_dbg_ack   <= 1'b1;
               end
            end
            D_ACK: begin
               r_dbg_state <= D_IDLE;
            end
            default: begin
               r_dbg_state <= D_IDLE;
            end
         endcase
      end
   end

   // Round-robin pointer only moves when both parked requesters compete.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr <= RR_MDU;
      end else if (w_contest) begin
         r_rr <= (r_rr == RR_MDU) ? RR_DBG : RR_MDU;
      end
   end

   // Starvation counter and the pipeline hold request it drives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_hold <= 1'b0;
      end else begin
         if (w_any_grant || !w_any_pend) begin
            r_cnt <= '0;
         end else if (r_cnt < LP_LIMIT) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end

         if (w_any_grant || !w_any_pend) begin
            r_hold <= 1'b0;
         end else if (r_cnt == LP_LIMIT) begin
            r_hold <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_eco32f_rf_wport_arbiter.sv
// Scoreboard bench for the register-file write-port arbiter (STARVE_LIMIT = 4).
module tb_eco32f_rf_wport_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_rf_r_we;
   logic [4:0]  pipe_rf_r_addr;
   logic [31:0] pipe_rf_r;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_result;
   logic        dbg_req;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack;
   logic        pipe_hold;
   logic        buf_valid;
   logic [4:0]  buf_addr;
   logic [31:0] buf_data;
   logic        wb_rf_r_we;
   logic [4:0]  wb_rf_r_addr;
   logic [31:0] wb_rf_r;

   int n_checks;
   int n_errs;

   // Expected register-file writes in commit order: {addr, data}.
   logic [36:0] sb[$];
   logic [36:0] mon_e;

   eco32f_rf_wport_arbiter #(
      .STARVE_LIMIT(4),
      .CNT_WIDTH   (8)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_rf_r_we  (pipe_rf_r_we),
      .pipe_rf_r_addr(pipe_rf_r_addr),
      .pipe_rf_r     (pipe_rf_r),
      .mdu_valid     (mdu_valid),
      .mdu_ready     (mdu_ready),
      .mdu_addr      (mdu_addr),
      .mdu_result    (mdu_result),
      .dbg_req       (dbg_req),
      .dbg_addr      (dbg_addr),
      .dbg_wdata     (dbg_wdata),
      .dbg_ack       (dbg_ack),
      .pipe_hold     (pipe_hold),
      .buf_valid     (buf_valid),
      .buf_addr      (buf_addr),
      .buf_data      (buf_data),
      .wb_rf_r_we    (wb_rf_r_we),
      .wb_rf_r_addr  (wb_rf_r_addr),
      .wb_rf_r       (wb_rf_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      sb.push_back({a, d});
   endtask

   task automatic drive_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
      pipe_rf_r_we   = we;
      pipe_rf_r_addr = a;
      pipe_rf_r      = d;
      if (we && a != 5'd0) expect_wr(a, d);
   endtask

   task automatic drive_mdu(input logic [4:0] a, input logic [31:0] d);
      mdu_valid  = 1'b1;
      mdu_addr   = a;
      mdu_result = d;
   endtask

   // Every observed write must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && wb_rf_r_we) begin
         check("wb_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("wb_addr_data", 64'({wb_rf_r_addr, wb_rf_r}), 64'(mon_e));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errs   = 0;
      rst = 1'b1;
      pipe_rf_r_we = 1'b0; pipe_rf_r_addr = '0; pipe_rf_r = '0;
      mdu_valid = 1'b0; mdu_addr = '0; mdu_result = '0;
      dbg_req = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      tick(); tick();
      check("rst_wb_we",     64'(wb_rf_r_we),   64'd0);
      check("rst_wb_addr",   64'(wb_rf_r_addr), 64'd0);
      check("rst_wb_data",   64'(wb_rf_r),      64'd0);
      check("rst_buf_valid", 64'(buf_valid),    64'd0);
      check("rst_hold",      64'(pipe_hold),    64'd0);
      check("rst_dbg_ack",   64'(dbg_ack),      64'd0);
      check("rst_mdu_ready", 64'(mdu_ready),    64'd1);
      rst = 1'b0;
      tick();

      // Pipeline-only write
      drive_pipe(1'b1, 5'd5, 32'h1234);
      tick();
      check("p_we",        64'(wb_rf_r_we), 64'd1);
      check("p_mdu_ready", 64'(mdu_ready),  64'd1);
      check("p_hold",      64'(pipe_hold),  64'd0);
      drive_pipe(1'b0, 5'd0, 32'h0);
      tick();
      check("p_we_off",    64'(wb_rf_r_we), 64'd0);

      // MDU parked behind three busy pipeline cycles
      drive_pipe(1'b1, 5'd10, 32'hA0);
      drive_mdu(5'd7, 32'hDEADBEEF);
      tick();
      mdu_valid = 1'b0;
      check("m_buf_valid1", 64'(buf_valid), 64'd1);
      check("m_buf_addr1",  64'(buf_addr),  64'd7);
      check("m_ready1",     64'(mdu_ready), 64'd0);
      drive_pipe(1'b1, 5'd11, 32'hA1);
      tick();
      check("m_buf_valid2", 64'(buf_valid), 64'd1);
      check("m_ready2",     64'(mdu_ready), 64'd0);
      drive_pipe(1'b1, 5'd12, 32'hA2);
      tick();
      check("m_buf_valid3", 64'(buf_valid), 64'd1);
      check("m_buf_data3",  64'(buf_data),  64'hDEADBEEF);
      drive_pipe(1'b0, 5'd0, 32'h0);
      expect_wr(5'd7, 32'hDEADBEEF);
      tick();
      check("m_wr_addr",    64'(wb_rf_r_addr), 64'd7);
      check("m_buf_empty",  64'(buf_valid),    64'd0);
      tick();

      // Starvation: buffer pending while the pipeline keeps writing
      drive_pipe(1'b1, 5'd1, 32'h100);
      drive_mdu(5'd8, 32'h88);
      tick();
      mdu_valid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         check("s_hold_low", 64'(pipe_hold), 64'd0);
         drive_pipe(1'b1, 5'd1, 32'h100 + 32'(i));
         tick();
      end
      check("s_hold_high", 64'(pipe_hold), 64'd1);
      drive_pipe(1'b1, 5'd1, 32'h106);
      tick();
      check("s_hold_persist", 64'(pipe_hold), 64'd1);
      drive_pipe(1'b0, 5'd0, 32'h0);
      expect_wr(5'd8, 32'h88);
      tick();
      check("s_hold_fell", 64'(pipe_hold), 64'd0);
      check("s_buf_empty", 64'(buf_valid), 64'd0);
      tick();

      // WAW drop: younger pipeline write to the parked register
      drive_pipe(1'b1, 5'd2, 32'h22);
      drive_mdu(5'd9, 32'h99);
      tick();
      mdu_valid = 1'b0;
      check("w_buf_valid", 64'(buf_valid), 64'd1);
      check("w_buf_addr",  64'(buf_addr),  64'd9);
      drive_pipe(1'b1, 5'd9, 32'h1);
      tick();
      check("w_dropped", 64'(buf_valid), 64'd0);
      drive_pipe(1'b0, 5'd0, 32'h0);
      repeat (4) tick();

      // Round-robin between parked MDU and debug
      drive_pipe(1'b1, 5'd2, 32'h200);
      drive_mdu(5'd3, 32'h33);
      dbg_req = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h44;
      tick();
      mdu_valid = 1'b0;
      drive_pipe(1'b0, 5'd0, 32'h0);
      expect_wr(5'd3, 32'h33);
      expect_wr(5'd4, 32'h44);
      tick();
      check("r1_first_addr", 64'(wb_rf_r_addr), 64'd3);
      check("r1_ack_low",    64'(dbg_ack),      64'd0);
      tick();
      check("r1_second_addr", 64'(wb_rf_r_addr), 64'd4);
      check("r1_ack_high",    64'(dbg_ack),      64'd1);
      dbg_req = 1'b0;
      tick();
      check("r1_ack_pulse", 64'(dbg_ack), 64'd0);
      drive_pipe(1'b1, 5'd2, 32'h201);
      drive_mdu(5'd3, 32'h3333);
      dbg_req = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h4444;
      tick();
      mdu_valid = 1'b0;
      drive_pipe(1'b0, 5'd0, 32'h0);
      expect_wr(5'd4, 32'h4444);
      expect_wr(5'd3, 32'h3333);
      tick();
      check("r2_first_addr", 64'(wb_rf_r_addr), 64'd4);
      check("r2_ack_high",   64'(dbg_ack),      64'd1);
      dbg_req = 1'b0;
      tick();
      check("r2_second_addr", 64'(wb_rf_r_addr), 64'd3);
      check("r2_ack_low",     64'(dbg_ack),      64'd0);
      tick();

      // Debug write to $0: acknowledged but not written
      dbg_req = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h55;
      tick();
      tick();
      check("z_ack", 64'(dbg_ack),    64'd1);
      check("z_we",  64'(wb_rf_r_we), 64'd0);
      dbg_req = 1'b0;
      tick();

      // Reset with the buffer full
      drive_pipe(1'b1, 5'd2, 32'h300);
      drive_mdu(5'd6, 32'h66);
      tick();
      mdu_valid = 1'b0;
      drive_pipe(1'b0, 5'd0, 32'h0);
      check("x_buf_full", 64'(buf_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("x_buf_cleared", 64'(buf_valid), 64'd0);
      check("x_hold",        64'(pipe_hold), 64'd0);
      check("x_we",          64'(wb_rf_r_we), 64'd0);
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
